// File: rtl/fifo_sync_pkg.sv
// fifo_sync_pkg: shared default sizing for the synchronous FIFO.
//   DEFAULT_DEPTH     - number of storage locations (power of two, >= 2)
//   DEFAULT_WIDTH     - data bits per location
//   DEFAULT_PTR_WIDTH - address bits, log2(DEFAULT_DEPTH)
package fifo_sync_pkg;
    localparam int DEFAULT_DEPTH     = 16;
    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_PTR_WIDTH = 4;
endpackage

// File: rtl/fifo_sync_mem.sv
// fifo_sync_mem: storage array for fifo_sync. Synchronous write port and a
// registered read port; intentionally has no reset so it maps onto RAM.
//   clk_i   - clock
//   we_i    - write enable, waddr_i/wdata_i sampled on the rising edge
//   re_i    - read enable, rdata_o loads mem[raddr_i] on the rising edge
//   rdata_o - registered read data, holds when re_i is low
module fifo_sync_mem
    import fifo_sync_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int PTR_WIDTH = DEFAULT_PTR_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [PTR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 re_i,
    input  logic [PTR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with wrap-toggle pointers, combinational
// full/empty flags and one-cycle error pulses for rejected accesses.
//   clk_i, rst_i      - clock, asynchronous active-high reset
//   wr_en_i, wdata_i  - write request and data
//   full_o            - DEPTH entries stored
//   wr_error_o        - pulse: write rejected because full on previous edge
//   rd_en_i, rdata_o  - read request, registered read data (1-cycle latency)
//   empty_o           - zero entries stored
//   rd_error_o        - pulse: read rejected because empty on previous edge
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int PTR_WIDTH = DEFAULT_PTR_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    output logic             wr_error_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             rd_error_o
);
    // MSB of each pointer is the wrap toggle; the rest is the address.
    logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic               wr_acc, rd_acc;
    logic               wr_error_q, rd_error_q;
    logic               rd_seen_q;
    logic [WIDTH-1:0]   mem_rdata;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]) &&
                     (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);

    assign wr_acc = wr_en_i && !full_o;
    assign rd_acc = rd_en_i && !empty_o;

    // Natural overflow of the PTR_WIDTH+1 bit add gives the modulo 2*DEPTH wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_error_q <= 1'b0;
            rd_error_q <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_error_q <= wr_en_i && full_o;
            rd_error_q <= rd_en_i && empty_o;
            if (rd_acc) rd_seen_q <= 1'b1;
        end
    end

    // Read and write never hit the same address in one edge: that needs
    // full (write rejected) or empty (read rejected).
    fifo_sync_mem #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .PTR_WIDTH(PTR_WIDTH)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (wr_acc),
        .waddr_i(wr_ptr_q[PTR_WIDTH-1:0]),
        .wdata_i(wdata_i),
        .re_i   (rd_acc),
        .raddr_i(rd_ptr_q[PTR_WIDTH-1:0]),
        .rdata_o(mem_rdata)
    );

    // The RAM read register has no reset; mask it until the first read
    // after reset so rdata_o reads 0 asynchronously under reset.
    assign rdata_o    = rd_seen_q ? mem_rdata : '0;
    assign wr_error_o = wr_error_q;
    assign rd_error_o = rd_error_q;
endmodule

// File: tb/tb_fifo_sync.sv
module tb_fifo_sync;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic [7:0] wdata = '0;
    logic       full_o, wr_error_o, empty_o, rd_error_o;
    logic [7:0] rdata_o;

    fifo_sync #(.DEPTH(16), .WIDTH(8), .PTR_WIDTH(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wdata_i(wdata), .full_o(full_o), .wr_error_o(wr_error_o),
        .rd_en_i(rd_en), .rdata_o(rdata_o), .empty_o(empty_o), .rd_error_o(rd_error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rdata;
        logic       wr_err;
        logic       rd_err;
        logic       full;
        logic       empty;
    } exp_t;

    int         checks = 0;
    int         failures = 0;
    exp_t       expq[$];
    logic [7:0] mq[$];          // reference FIFO contents
    logic [7:0] m_rdata = '0;   // reference rdata_o

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one edge worth of stimulus and push the expected post-edge state.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        exp_t e;
        bit   f, em;
        @(negedge clk);
        wr_en = w; rd_en = r; wdata = d;
        f  = (mq.size() == D);
        em = (mq.size() == 0);
        e.wr_err = w && f;
        e.rd_err = r && em;
        if (r && !em) m_rdata = mq.pop_front();
        if (w && !f) mq.push_back(d);
        e.rdata = m_rdata;
        e.full  = (mq.size() == D);
        e.empty = (mq.size() == 0);
        expq.push_back(e);
    endtask

    // Monitor: compares the DUT after every edge that has an expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rdata",  32'(rdata_o),    32'(e.rdata));
                chk("wr_err", 32'(wr_error_o), 32'(e.wr_err));
                chk("rd_err", 32'(rd_error_o), 32'(e.rd_err));
                chk("full",   32'(full_o),     32'(e.full));
                chk("empty",  32'(empty_o),    32'(e.empty));
            end
        end
    end

    initial begin
        int wn, rn, wg, rg;
        logic w, r;

        // Reset values, before any clock edge.
        #2;
        chk("rst_rdata", 32'(rdata_o), 32'h0);
        chk("rst_empty", 32'(empty_o), 32'h1);
        chk("rst_full",  32'(full_o),  32'h0);
        chk("rst_wrerr", 32'(wr_error_o), 32'h0);
        chk("rst_rderr", 32'(rd_error_o), 32'h0);
        #5 rst = 1'b0;   // t=7: first edge with rst low is t=15

        // Fill: 16 writes of A0..AF.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'hA0 + i));
        @(posedge clk); #2;
        chk("fill_full",  32'(full_o),  32'h1);
        chk("fill_empty", 32'(empty_o), 32'h0);

        // Overflow: 17th write (byte EE) must be rejected.
        cycle(1'b1, 1'b0, 8'hEE);
        @(posedge clk); #2;
        chk("ovf_wrerr", 32'(wr_error_o), 32'h1);
        chk("ovf_full",  32'(full_o),     32'h1);

        // Underflow: 17 reads, data A0..AF in order, then one rejected read.
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 8'h00);
        @(posedge clk); #2;
        chk("udf_rderr", 32'(rd_error_o), 32'h1);
        chk("udf_hold",  32'(rdata_o),    32'hAF);
        chk("udf_empty", 32'(empty_o),    32'h1);

        // Write+read while empty: write taken, read rejected, no fall-through.
        cycle(1'b1, 1'b1, 8'h3C);
        cycle(1'b0, 1'b1, 8'h00);
        // Fill with random bytes, then write+read while full.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'($urandom));
        cycle(1'b1, 1'b1, 8'h77);
        // Drain, random data checked in write order.
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);

        // Concurrent traffic with independent random 1-10 cycle gaps.
        wn = 0; rn = 0; wg = 0; rg = 0;
        while (wn < 100 || rn < 100) begin
            w = (wn < 100) && (wg == 0);
            r = (rn < 100) && (rg == 0);
            cycle(w, r, 8'($urandom));
            if (w) begin wn++; wg = $urandom_range(1, 10); end
            else if (wg > 0) wg--;
            if (r) begin rn++; rg = $urandom_range(1, 10); end
            else if (rg > 0) rg--;
        end

        // Async reset with 5 entries stored.
        while (mq.size() > 0) cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i));
        cycle(1'b0, 1'b1, 8'h00);   // rdata_o becomes 0x50, 4 entries left
        cycle(1'b1, 1'b0, 8'h55);   // back to 5 entries
        @(posedge clk); #3;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        #1;
        chk("arst_empty", 32'(empty_o), 32'h1);
        chk("arst_full",  32'(full_o),  32'h0);
        chk("arst_rdata", 32'(rdata_o), 32'h0);
        mq.delete();
        m_rdata = '0;
        @(posedge clk); #1;
        chk("arst_hold_empty", 32'(empty_o), 32'h1);
        #2 rst = 1'b0;

        // After reset: old entries gone, FIFO works again.
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, 8'h5A);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        @(posedge clk); #2;
        chk("post_rst_rdata", 32'(rdata_o), 32'h5A);
        chk("scoreboard_drained", 32'(expq.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 Parameter DEPTH, default 16, number of storage locations; SHALL be a power of two, at least 2.
REQ-002 Parameter WIDTH, default 8, data bits per location.
REQ-003 Parameter PTR_WIDTH, default 4, address bits; SHALL equal log2(DEPTH).
REQ-004 Port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port rst_i, input, 1, asynchronous active-high reset.
REQ-006 Port wr_en_i, input, 1, write request, sampled at the rising edge.
REQ-007 Port wdata_i, input, WIDTH, write data, sampled with wr_en_i.
REQ-008 Port full_o, output, 1, high when DEPTH entries are stored.
REQ-009 Port wr_error_o, output, 1, one-cycle pulse flagging a rejected write.
REQ-010 Port rd_en_i, input, 1, read request, sampled at the rising edge.
REQ-011 Port rdata_o, output, WIDTH, registered read data.
REQ-012 Port empty_o, output, 1, high when zero entries are stored.
REQ-013 Port rd_error_o, output, 1, one-cycle pulse flagging a rejected read.

Function
REQ-014 Write pointer and read pointer SHALL each be PTR_WIDTH+1 bits: PTR_WIDTH address bits plus one wrap toggle bit.
REQ-015 empty_o SHALL be combinational and high exactly when both pointers are equal, including the toggle bit.
REQ-016 full_o SHALL be combinational and high exactly when the address bits are equal and the toggle bits differ.
REQ-017 Accepted write: wr_en_i=1 and full_o=0 at an edge SHALL store wdata_i at the write address and increment the write pointer.
REQ-018 Accepted read: rd_en_i=1 and empty_o=0 at an edge SHALL load the word at the read address into rdata_o and increment the read pointer; latency is 1 clock.
REQ-019 rdata_o SHALL hold its last value when no read is accepted.
REQ-020 Rejected write: wr_en_i=1 while full_o=1 SHALL leave memory and pointers unchanged and set wr_error_o high for the following cycle only.
REQ-021 Rejected read: rd_en_i=1 while empty_o=1 SHALL leave pointers and rdata_o unchanged and set rd_error_o high for the following cycle only.
REQ-022 Pointer increment SHALL wrap modulo 2*DEPTH, so the address wraps from DEPTH-1 to 0 and the toggle bit inverts.
REQ-023 Simultaneous write and read when neither full nor empty: both SHALL be accepted, and the occupancy is unchanged.
REQ-024 Simultaneous write and read when full: the read SHALL be accepted and the write SHALL be rejected with wr_error_o.
REQ-025 Simultaneous write and read when empty: the write SHALL be accepted and the read SHALL be rejected with rd_error_o; there is no fall-through.
REQ-026 Data SHALL be returned in strict first-in-first-out order.

Reset
REQ-027 While rst_i=1, both pointers SHALL be 0, rdata_o=0, wr_error_o=0, rd_error_o=0, empty_o=1 and full_o=0, independent of the clock.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries immediately.
REQ-030 The first accepted operation after reset SHALL be at the first rising edge at which rst_i=0.

Structure
REQ-031 Package fifo_sync_pkg SHALL hold the default DEPTH, WIDTH and PTR_WIDTH constants.
REQ-032 The storage array SHALL be a sub-module fifo_sync_mem: synchronous write port, registered read port, and no reset.
REQ-033 Pointer logic, flag logic and error logic SHALL reside in fifo_sync.

Verification
REQ-034 Fill: reset, then 16 consecutive writes -> full_o=1 after the 16th edge, empty_o=0, no error pulses.
REQ-035 Drain: fill with 16 random bytes, then 16 reads -> rdata_o matches the bytes in write order, one cycle after each read; empty_o=1 after the last read.
REQ-036 Overflow: 17 consecutive writes -> wr_error_o pulses once after the 17th edge, full_o stays 1, and the 17th byte is never read back.
REQ-037 Underflow: fill 16, then 17 reads -> rd_error_o pulses once after the 17th read, and rdata_o holds the 16th byte.
REQ-038 Concurrent: 100 writes and 100 reads, each followed by a random 1-10 cycle gap -> the reference model matches every rdata_o, and every error pulse corresponds to a full or empty condition.
REQ-039 Async reset: assert rst_i between clock edges with 5 entries stored -> empty_o=1, full_o=0 and rdata_o=0 before the next edge.
